// File: rtl/his_builder_pingpong.sv
// dToF histogram builder: two ping-pong banks of saturating bin counters, lazily cleared on swap.
// Latency: write result (bin_count) and read result (rd_data) both one cycle after the request.
// No backpressure: a write and a read may be accepted every cycle, independently.
module his_builder_pingpong #(
    parameter int BIN_NUM  = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 8,
    parameter int PIX_NUM  = 4,
    parameter int PIX_W    = 2,
    parameter int DATA_NUM = 2,
    parameter int ACQ_NUM  = 3
) (
    input  logic              clk,
    input  logic              res,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  bin_count,
    output logic              wr_valid,
    input  logic              rd_en,
    input  logic [PIX_W-1:0]  rd_pix,
    input  logic [ADDR_W-1:0] rd_bin,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              his_num,
    output logic              frame_done,
    output logic              sat_flag,
    output logic              err_addr
);

    localparam int CELLS = PIX_NUM * BIN_NUM;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int IN_W  = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   BIN_LIM  = (ADDR_W+1)'(BIN_NUM);
    localparam logic [PIX_W:0]    PIX_LIM  = (PIX_W+1)'(PIX_NUM);
    localparam logic [IN_W-1:0]   IN_LAST  = IN_W'(DATA_NUM - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX_NUM - 1);
    localparam logic [ACQ_W-1:0]  ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
    localparam logic [IDX_W-1:0]  BIN_STRIDE = IDX_W'(BIN_NUM);

    logic [IN_W-1:0]  r_in_cnt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [ACQ_W-1:0] r_acq_cnt;
    logic             r_his_num;
    logic [CELLS-1:0] r_vld [2];
    logic [CNT_W-1:0] r_mem [2][CELLS];

    logic [CNT_W-1:0] r_bin_count;
    logic             r_wr_valid;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_frame_done;
    logic             r_sat_flag;
    logic             r_err_addr;

    logic             w_act;
    logic             w_addr_ok;
    logic             w_wr_hit;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_old_vld;
    logic [CNT_W-1:0] w_old;
    logic             w_old_sat;
    logic [CNT_W-1:0] w_new;
    logic             w_frame_end;
    logic             w_rd_ok;
    logic [IDX_W-1:0] w_rd_idx;
    logic [CNT_W-1:0] w_rd_val;

    assign w_act     = ~r_his_num;
    assign w_addr_ok = {1'b0, addr} < BIN_LIM;
    assign w_wr_hit  = wr_en && w_addr_ok;
    assign w_wr_idx  = IDX_W'(r_pix_cnt) * BIN_STRIDE + IDX_W'(addr);

    // A cleared valid bit makes the stale counter read as zero, so a swap never sweeps the array.
    assign w_old_vld = r_vld[w_act][w_wr_idx];
    assign w_old     = w_old_vld ? r_mem[w_act][w_wr_idx] : '0;
    assign w_old_sat = w_old_vld && (w_old == CNT_MAX);
    assign w_new     = !w_old_vld ? CNT_ONE : (w_old_sat ? CNT_MAX : w_old + CNT_ONE);

    assign w_frame_end = wr_en && (r_in_cnt == IN_LAST) && (r_pix_cnt == PIX_LAST)
                         && (r_acq_cnt == ACQ_LAST);

    assign w_rd_ok  = ({1'b0, rd_pix} < PIX_LIM) && ({1'b0, rd_bin} < BIN_LIM);
    assign w_rd_idx = IDX_W'(rd_pix) * BIN_STRIDE + IDX_W'(rd_bin);
    assign w_rd_val = (w_rd_ok && r_vld[r_his_num][w_rd_idx]) ? r_mem[r_his_num][w_rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            r_mem[w_act][w_wr_idx] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_in_cnt     <= '0;
            r_pix_cnt    <= '0;
            r_acq_cnt    <= '0;
            r_his_num    <= 1'b1;
            r_vld[0]     <= '0;
            r_vld[1]     <= '0;
            r_bin_count  <= '0;
            r_wr_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_sat_flag   <= 1'b0;
            r_err_addr   <= 1'b0;
        end else begin
            r_wr_valid <= w_wr_hit;
            if (w_wr_hit) begin
                r_bin_count              <= w_new;
                r_vld[w_act][w_wr_idx]   <= 1'b1;
            end

            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_val;
            end

            // Out-of-range hits still count as events so the frame length stays fixed.
            if (wr_en) begin
                if (r_in_cnt == IN_LAST) begin
                    r_in_cnt <= '0;
                    if (r_pix_cnt == PIX_LAST) begin
                        r_pix_cnt <= '0;
                        if (r_acq_cnt == ACQ_LAST) begin
                            r_acq_cnt <= '0;
                        end else begin
                            r_acq_cnt <= r_acq_cnt + ACQ_W'(1);
                        end
                    end else begin
                        r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                    end
                end else begin
                    r_in_cnt <= r_in_cnt + IN_W'(1);
                end
            end

            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                // The old readout bank becomes active; the last write above lands in the other bank.
                r_his_num        <= ~r_his_num;
                r_vld[r_his_num] <= '0;
                r_sat_flag       <= 1'b0;
                r_err_addr       <= 1'b0;
            end else begin
                if (w_wr_hit && w_old_sat) begin
                    r_sat_flag <= 1'b1;
                end
                if (wr_en && !w_addr_ok) begin
                    r_err_addr <= 1'b1;
                end
            end
        end
    end

    assign bin_count  = r_bin_count;
    assign wr_valid   = r_wr_valid;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign his_num    = r_his_num;
    assign frame_done = r_frame_done;
    assign sat_flag   = r_sat_flag;
    assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_his_builder_pingpong.sv
// Bench: default instance (a_) for swap/readout/reset, narrow-counter wide-address instance (b_)
// for saturation and out-of-range addresses.
module tb_his_builder_pingpong;

    logic       clk = 1'b0;
    logic       res;
    logic       wr_en_a, wr_en_b;
    logic [4:0] addr;
    logic       rd_en;
    logic [1:0] rd_pix;
    logic [4:0] rd_bin;

    logic [7:0] a_bin_count, a_rd_data;
    logic       a_wr_valid, a_rd_valid, a_his_num, a_frame_done, a_sat_flag, a_err_addr;
    logic [1:0] b_bin_count, b_rd_data;
    logic       b_wr_valid, b_rd_valid, b_his_num, b_frame_done, b_sat_flag, b_err_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    his_builder_pingpong u_a (
        .clk(clk), .res(res), .wr_en(wr_en_a), .addr(addr[3:0]),
        .bin_count(a_bin_count), .wr_valid(a_wr_valid),
        .rd_en(rd_en), .rd_pix(rd_pix), .rd_bin(rd_bin[3:0]),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .his_num(a_his_num),
        .frame_done(a_frame_done), .sat_flag(a_sat_flag), .err_addr(a_err_addr)
    );

    his_builder_pingpong #(.CNT_W(2), .ADDR_W(5)) u_b (
        .clk(clk), .res(res), .wr_en(wr_en_b), .addr(addr),
        .bin_count(b_bin_count), .wr_valid(b_wr_valid),
        .rd_en(rd_en), .rd_pix(rd_pix), .rd_bin(rd_bin),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .his_num(b_his_num),
        .frame_done(b_frame_done), .sat_flag(b_sat_flag), .err_addr(b_err_addr)
    );

    typedef struct {
        int ph;
        bit sel;
        bit rd;
        int pix;
        int bin;
        bit exp_vld;
        int exp_dat;
    } rd_vec_t;

    rd_vec_t tbl[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input bit sel, input logic [31:0] va, input logic [31:0] vb);
        return sel ? vb : va;
    endfunction

    task automatic run_tbl(input int ph);
        foreach (tbl[i]) begin
            if (tbl[i].ph == ph) begin
                rd_en  = tbl[i].rd;
                rd_pix = 2'(tbl[i].pix);
                rd_bin = 5'(tbl[i].bin);
                tick;
                chk($sformatf("rd_valid v%0d", i),
                    pick(tbl[i].sel, 32'(a_rd_valid), 32'(b_rd_valid)), 32'(tbl[i].exp_vld));
                if (tbl[i].exp_vld) begin
                    chk($sformatf("rd_data v%0d", i),
                        pick(tbl[i].sel, 32'(a_rd_data), 32'(b_rd_data)), 32'(tbl[i].exp_dat));
                end
            end
        end
        rd_en = 1'b0;
    endtask

    // Drives n_ev write events from sequencer position 0 into a freshly cleared active bank.
    // Event bad_k uses address 16 (out of range); optional reads of bin 5 run alongside.
    task automatic run_events(input bit sel, input int n_ev, input int bad_k, input logic [4:0] a,
                              input bit do_rd, input int exp_rd, input logic his0, input int prev_bc);
        int  mdl[4];
        int  maxv;
        int  pix;
        int  exp_bc;
        bit  sat, err, bad, last;
        maxv   = sel ? 3 : 255;
        mdl    = '{default: 0};
        sat    = 1'b0;
        err    = 1'b0;
        exp_bc = prev_bc;
        for (int k = 0; k < n_ev; k++) begin
            pix     = (k / 2) % 4;
            bad     = (k == bad_k);
            last    = (k == 23);
            wr_en_a = !sel;
            wr_en_b = sel;
            addr    = bad ? 5'd16 : a;
            rd_en   = do_rd;
            rd_pix  = 2'(k % 4);
            rd_bin  = 5'd5;
            tick;
            if (!bad) begin
                if (mdl[pix] == maxv) sat = 1'b1;
                else mdl[pix] = mdl[pix] + 1;
                exp_bc = mdl[pix];
            end else begin
                err = 1'b1;
            end
            if (last) begin
                sat = 1'b0;
                err = 1'b0;
            end
            chk($sformatf("wr_valid k%0d", k), pick(sel, 32'(a_wr_valid), 32'(b_wr_valid)), 32'(!bad));
            chk($sformatf("bin_count k%0d", k), pick(sel, 32'(a_bin_count), 32'(b_bin_count)), exp_bc);
            chk($sformatf("frame_done k%0d", k), pick(sel, 32'(a_frame_done), 32'(b_frame_done)), 32'(last));
            chk($sformatf("sat_flag k%0d", k), pick(sel, 32'(a_sat_flag), 32'(b_sat_flag)), 32'(sat));
            chk($sformatf("err_addr k%0d", k), pick(sel, 32'(a_err_addr), 32'(b_err_addr)), 32'(err));
            chk($sformatf("his_num k%0d", k), pick(sel, 32'(a_his_num), 32'(b_his_num)),
                last ? 32'(!his0) : 32'(his0));
            if (do_rd) begin
                chk($sformatf("rd_valid k%0d", k), pick(sel, 32'(a_rd_valid), 32'(b_rd_valid)), 32'd1);
                chk($sformatf("rd_data k%0d", k), pick(sel, 32'(a_rd_data), 32'(b_rd_data)), exp_rd);
            end
        end
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        rd_en   = 1'b0;
        if (n_ev == 24) begin
            tick;
            chk("frame_done drop", pick(sel, 32'(a_frame_done), 32'(b_frame_done)), 32'd0);
            chk("wr_valid idle", pick(sel, 32'(a_wr_valid), 32'(b_wr_valid)), 32'd0);
            chk("bin_count hold", pick(sel, 32'(a_bin_count), 32'(b_bin_count)), exp_bc);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " a_bin_count"}, 32'(a_bin_count), 32'd0);
        chk({tag, " a_wr_valid"}, 32'(a_wr_valid), 32'd0);
        chk({tag, " a_rd_data"}, 32'(a_rd_data), 32'd0);
        chk({tag, " a_rd_valid"}, 32'(a_rd_valid), 32'd0);
        chk({tag, " a_his_num"}, 32'(a_his_num), 32'd1);
        chk({tag, " a_frame_done"}, 32'(a_frame_done), 32'd0);
        chk({tag, " a_sat_flag"}, 32'(a_sat_flag), 32'd0);
        chk({tag, " a_err_addr"}, 32'(a_err_addr), 32'd0);
        chk({tag, " b_his_num"}, 32'(b_his_num), 32'd1);
        chk({tag, " b_bin_count"}, 32'(b_bin_count), 32'd0);
    endtask

    initial begin
        // {phase, instance(0=a,1=b), rd_en, pix, bin, exp rd_valid, exp rd_data}
        tbl.push_back('{1, 1'b0, 1'b1, 0, 5, 1'b1, 6});
        tbl.push_back('{1, 1'b0, 1'b1, 1, 5, 1'b1, 6});
        tbl.push_back('{1, 1'b0, 1'b1, 2, 5, 1'b1, 6});
        tbl.push_back('{1, 1'b0, 1'b1, 3, 5, 1'b1, 6});
        tbl.push_back('{1, 1'b0, 1'b1, 0, 4, 1'b1, 0});
        tbl.push_back('{1, 1'b0, 1'b1, 3, 4, 1'b1, 0});
        tbl.push_back('{1, 1'b0, 1'b0, 0, 5, 1'b0, 0});
        tbl.push_back('{2, 1'b0, 1'b1, 0, 7, 1'b1, 6});
        tbl.push_back('{2, 1'b0, 1'b1, 1, 7, 1'b1, 6});
        tbl.push_back('{2, 1'b0, 1'b1, 2, 7, 1'b1, 6});
        tbl.push_back('{2, 1'b0, 1'b1, 3, 7, 1'b1, 6});
        tbl.push_back('{2, 1'b0, 1'b1, 0, 5, 1'b1, 0});
        tbl.push_back('{2, 1'b0, 1'b1, 2, 5, 1'b1, 0});
        tbl.push_back('{3, 1'b0, 1'b1, 0, 7, 1'b1, 0});
        tbl.push_back('{3, 1'b0, 1'b1, 3, 7, 1'b1, 0});
        tbl.push_back('{4, 1'b1, 1'b1, 0, 5, 1'b1, 3});
        tbl.push_back('{4, 1'b1, 1'b1, 1, 5, 1'b1, 3});
        tbl.push_back('{4, 1'b1, 1'b1, 2, 5, 1'b1, 3});
        tbl.push_back('{4, 1'b1, 1'b1, 3, 5, 1'b1, 3});
        tbl.push_back('{4, 1'b1, 1'b1, 0, 16, 1'b1, 0});
        tbl.push_back('{4, 1'b1, 1'b1, 3, 31, 1'b1, 0});
        tbl.push_back('{5, 1'b1, 1'b1, 0, 5, 1'b1, 3});
        tbl.push_back('{5, 1'b1, 1'b1, 1, 0, 1'b1, 0});
        tbl.push_back('{5, 1'b1, 1'b1, 1, 5, 1'b1, 3});

        res     = 1'b1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        addr    = '0;
        rd_en   = 1'b0;
        rd_pix  = '0;
        rd_bin  = '0;
        #2 res = 1'b0;
        tick;
        tick;
        chk_reset_state("por");
        res = 1'b1;
        tick;

        // Frame 1 into bank 0; readout bank 1 is empty, including the read on the swap edge.
        run_events(1'b0, 24, -1, 5'd5, 1'b1, 0, 1'b1, 0);
        chk("a his after frame1", 32'(a_his_num), 32'd0);
        run_tbl(1);

        // Frame 2 into bank 1 while bank 0 (frame 1) is read every cycle.
        run_events(1'b0, 24, -1, 5'd7, 1'b1, 6, 1'b0, 6);
        chk("a his after frame2", 32'(a_his_num), 32'd1);
        run_tbl(2);

        // Partial frame 3 into the lazily cleared bank 0, then a mid-frame reset.
        run_events(1'b0, 10, -1, 5'd7, 1'b0, 0, 1'b1, 6);
        #2 res = 1'b0;
        #1;
        chk_reset_state("mid");
        tick;
        res = 1'b1;
        tick;
        run_tbl(3);
        run_events(1'b0, 24, -1, 5'd5, 1'b0, 0, 1'b1, 0);
        chk("a his after restart", 32'(a_his_num), 32'd0);

        // Saturation with 2-bit counters.
        run_events(1'b1, 24, -1, 5'd5, 1'b0, 0, 1'b1, 0);
        chk("b his after frame1", 32'(b_his_num), 32'd0);
        run_tbl(4);

        // Out-of-range address on the first event: no storage change, still counted.
        run_events(1'b1, 24, 0, 5'd5, 1'b0, 0, 1'b0, 3);
        chk("b his after frame2", 32'(b_his_num), 32'd1);
        run_tbl(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
